// File: rtl/universal_reg_n_pkg.sv
// Shared definitions for the universal register and the controllers that drive it.
package universal_reg_n_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_LOAD = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_SHR  = 3'b011;
    localparam mode_t MODE_ROTL = 3'b100;
    localparam mode_t MODE_ROTR = 3'b101;
    localparam mode_t MODE_UP   = 3'b110;
    localparam mode_t MODE_DOWN = 3'b111;

endpackage

// File: rtl/universal_reg_n_reg_next_mux.sv
// Combinational next-state selector for the universal register.
module reg_next_mux
    import universal_reg_n_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sil,
    input  logic             i_sir,
    input  mode_t            i_mode,
    output logic [WIDTH-1:0] o_next
);

    // Pick the value the register takes on the next enabled edge.
    always_comb begin
        o_next = i_q;
        case (i_mode)
            MODE_LOAD: o_next = i_d;
            MODE_SHL:  o_next = {i_q[WIDTH-2:0], i_sir};
            MODE_SHR:  o_next = {i_sil, i_q[WIDTH-1:1]};
            MODE_ROTL: o_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            MODE_ROTR: o_next = {i_q[0], i_q[WIDTH-1:1]};
            MODE_UP:   o_next = i_q + 1'b1;
            MODE_DOWN: o_next = i_q - 1'b1;
            default:   o_next = i_q;
        endcase
    end

endmodule

// File: rtl/universal_reg_n.sv
// Universal WIDTH-bit register: hold, load, shift, rotate, count up/down.
// TC flags the cycle before a counting wrap so units cascade via EN.
module universal_reg_n
    import universal_reg_n_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter     RESET_VALUE = 0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] Q,
    output logic             SOL,
    output logic             SOR,
    output logic             TC
);

    // Clear value narrowed (or widened) to the register width.
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic             w_all_ones;
    logic             w_all_zero;

    reg_next_mux #(
        .WIDTH (WIDTH)
    ) u_next_mux (
        .i_q    (r_q),
        .i_d    (D),
        .i_sil  (SIL),
        .i_sir  (SIR),
        .i_mode (MODE),
        .o_next (w_next)
    );

    // Storage: asynchronous clear wins, otherwise update only when enabled.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_q <= RST_Q;
        end else if (EN) begin
            r_q <= w_next;
        end
    end

    assign w_all_ones = &r_q;
    assign w_all_zero = ~|r_q;

    assign Q   = r_q;
    assign SOL = r_q[WIDTH-1];
    assign SOR = r_q[0];
    assign TC  = EN & (((MODE == MODE_UP) & w_all_ones) |
                       ((MODE == MODE_DOWN) & w_all_zero));

endmodule

// File: tb/tb_universal_reg_n.sv
// Self-checking bench for universal_reg_n (WIDTH=8, RESET_VALUE=A5).
// Directed test-plan steps followed by a randomized run against an
// arithmetic reference model.
module tb_universal_reg_n;

    localparam int W = 8;

    logic         CLK;
    logic         CLR;
    logic         EN;
    logic [2:0]   MODE;
    logic [W-1:0] D;
    logic         SIL;
    logic         SIR;
    logic [W-1:0] Q;
    logic         SOL;
    logic         SOR;
    logic         TC;

    int n_asserts = 0;
    int n_fail    = 0;
    int m_q;                // reference register value, 0..255

    universal_reg_n #(
        .WIDTH       (W),
        .RESET_VALUE (8'hA5)
    ) dut (
        .CLK  (CLK),
        .CLR  (CLR),
        .EN   (EN),
        .MODE (MODE),
        .D    (D),
        .SIL  (SIL),
        .SIR  (SIR),
        .Q    (Q),
        .SOL  (SOL),
        .SOR  (SOR),
        .TC   (TC)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference next value, written as plain arithmetic on integers.
    function automatic int ref_next(int q, bit en, int mode, int d, int sil, int sir);
        if (!en) return q;
        case (mode)
            1:       return d;
            2:       return (q * 2 + sir) % 256;
            3:       return q / 2 + sil * 128;
            4:       return (q * 2) % 256 + q / 128;
            5:       return q / 2 + (q % 2) * 128;
            6:       return (q + 1) % 256;
            7:       return (q + 255) % 256;
            default: return q;
        endcase
    endfunction

    function automatic int ref_tc(int q, bit en, int mode);
        return (en && ((mode == 6 && q == 255) || (mode == 7 && q == 0))) ? 1 : 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(string tag);
        chk({tag, ".Q"},   Q,   m_q);
        chk({tag, ".SOL"}, SOL, (m_q / 128) % 2);
        chk({tag, ".SOR"}, SOR, m_q % 2);
        $display("%s: Q=%02h SOL=%0b SOR=%0b TC=%0b", tag, Q, SOL, SOR, TC);
    endtask

    task automatic drive(bit en, int mode, int d, bit sil, bit sir);
        EN   = en;
        MODE = mode[2:0];
        D    = d[7:0];
        SIL  = sil;
        SIR  = sir;
    endtask

    // Called at a falling edge: check TC, clock once, check the result.
    task automatic step(string tag, bit check_tc);
        int exp_q;
        #1;
        if (check_tc) chk({tag, ".TC"}, TC, ref_tc(m_q, EN, MODE));
        if (EN) begin
            n_asserts++;
            assert (!$isunknown(MODE))
            else begin
                n_fail++;
                $error("FAIL %s.mode_known: observed %b expected no X", tag, MODE);
            end
        end
        exp_q = ref_next(m_q, EN, MODE, D, SIL, SIR);
        @(posedge CLK);
        #1;
        m_q = exp_q;
        chk_outputs(tag);
        @(negedge CLK);
    endtask

    initial begin
        CLR = 1'b1;
        drive(0, 0, 0, 0, 0);

        // Clear dropped mid clock-high, away from any edge.
        @(posedge CLK);
        #2;
        CLR = 1'b0;
        #1;
        m_q = 8'hA5;
        chk_outputs("clr_async");
        chk("clr_async.TC", TC, 0);
        @(posedge CLK);
        #1;
        chk_outputs("clr_held");
        @(negedge CLK);
        CLR = 1'b1;

        drive(1, 1, 8'h3C, 0, 0);   step("load_3c", 1);
        chk("load_3c.const", Q, 8'h3C);
        drive(1, 2, 8'h00, 0, 1);   step("shl1", 1);
        step("shl2", 1);
        drive(1, 3, 8'hFF, 0, 1);   step("shr1", 1);

        drive(1, 1, 8'h81, 1, 1);   step("load_81", 1);
        drive(1, 4, 8'h00, 0, 0);   step("rotl", 1);
        chk("rotl.const", Q, 8'h03);
        drive(1, 5, 8'h00, 1, 1);   step("rotr1", 1);
        chk("rotr1.const", Q, 8'h81);
        step("rotr2", 1);
        chk("rotr2.const", Q, 8'hC0);

        drive(1, 1, 8'hFE, 0, 0);   step("load_fe", 1);
        drive(1, 6, 8'h00, 0, 0);
        #1; chk("up_fe.TC", TC, 0);
        step("up_to_ff", 1);
        #1; chk("up_ff.TC", TC, 1);
        step("up_wrap", 1);
        chk("up_wrap.const", Q, 8'h00);
        #1; chk("up_00.TC", TC, 0);
        drive(1, 7, 8'h00, 0, 0);
        #1; chk("down_00.TC", TC, 1);
        step("down_wrap", 1);
        chk("down_wrap.const", Q, 8'hFF);

        drive(0, 6, 8'h00, 1, 1);
        #1; chk("en0_ff.TC", TC, 0);
        for (int i = 0; i < 3; i++) step("en0_hold", 1);
        chk("en0_hold.const", Q, 8'hFF);
        EN = 1'b1;
        #1; chk("en1_ff.TC", TC, 1);

        drive(1, 1, 8'h10, 0, 0);   step("load_10", 1);
        drive(1, 6, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) step("count_up", 1);
        chk("count_up.const", Q, 8'h13);
        #2;
        CLR = 1'b0;
        #1;
        m_q = 8'hA5;
        chk_outputs("clr_mid_count");
        @(posedge CLK);
        #1;
        chk_outputs("clr_mid_held");
        @(negedge CLK);
        CLR = 1'b1;
        step("after_clr", 1);
        chk("after_clr.const", Q, 8'hA6);

        // Randomized run; loads favour 00/FF so wraps and TC get exercised.
        for (int i = 0; i < 300; i++) begin
            int d;
            d = (($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 255 : 0)
                                            : int'($urandom_range(0, 255)));
            drive(($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)), d,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step("rand", 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
